// File: rtl/ram_slot_sequencer.sv
// Time-slot sequencer for the shared SRAM: DMA owns S1-S3, the 6502 data port owns S4-S7.
// Tracks bus phase from PHI1 with a 7M state counter and registers every SRAM strobe.
module ram_slot_sequencer #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              C7M,
    input  logic              RES,
    input  logic              PHI1,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              bus_inc,
    output logic [2:0]        S,
    output logic [ADDR_W-1:0] RA,
    output logic              nRAMCS,
    output logic              nRAMWE,
    output logic              RDOE,
    output logic              RDsrc,
    input  logic [DATA_W-1:0] RD
);

    typedef enum logic [2:0] {
        IDLE, D_SETUP, D_STROBE, D_HOLD, B_SETUP, B_ACTIVE
    } slotState_t;

    slotState_t  state, stateNext;
    logic        phi1Reg, phi0Seen, syncEdge;
    logic        busWeReg, busWeNext;
    logic [2:0]  sNext;
    logic        ackNext, incNext, csNext, weNext, rdoeNext, srcNext;
    logic [ADDR_W-1:0] raNext;
    logic [DATA_W-1:0] rdataNext;

    // Write data is muxed onto the SRAM bus outside this block under RDsrc.
    logic unusedWdata;
    assign unusedWdata = ^dma_wdata;

    assign syncEdge = PHI1 & ~phi1Reg & phi0Seen;

    always_comb begin
        sNext     = S;
        stateNext = state;
        ackNext   = 1'b0;
        incNext   = 1'b0;
        busWeNext = busWeReg;

        if (syncEdge)         sNext = 3'd1;
        else if (S == 3'd0)   sNext = 3'd0;
        else if (S == 3'd7)   sNext = 3'd7;
        else                  sNext = S + 3'd1;

        // A sync edge ends whatever slot is in flight; only IDLE or a finished bus access may grant DMA.
        if (syncEdge) begin
            incNext = (state == B_ACTIVE);
            if ((state == IDLE || state == B_ACTIVE) && dma_req && S != 3'd0)
                stateNext = D_SETUP;
            else
                stateNext = IDLE;
        end else if (S == 3'd3) begin
            ackNext   = (state == D_HOLD);
            stateNext = B_SETUP;
        end else if (S == 3'd4) begin
            if (bus_sel) begin
                stateNext = B_ACTIVE;
                busWeNext = bus_we;
            end else begin
                stateNext = IDLE;
            end
        end else begin
            case (state)
                D_SETUP:  stateNext = D_STROBE;
                D_STROBE: stateNext = D_HOLD;
                D_HOLD: begin
                    stateNext = IDLE;
                    ackNext   = 1'b1;
                end
                default:  stateNext = state;
            endcase
        end
    end

    always_comb begin
        raNext    = RA;
        csNext    = 1'b1;
        weNext    = 1'b1;
        rdoeNext  = 1'b0;
        srcNext   = RDsrc;
        rdataNext = ackNext ? RD : dma_rdata;
        case (stateNext)
            D_SETUP, D_STROBE, D_HOLD: begin
                raNext   = dma_addr;
                csNext   = 1'b0;
                rdoeNext = dma_we;
                srcNext  = 1'b1;
                weNext   = (stateNext == D_STROBE) ? ~dma_we : 1'b1;
            end
            B_SETUP: begin
                raNext  = bus_addr;
                srcNext = 1'b0;
            end
            B_ACTIVE: begin
                raNext   = bus_addr;
                csNext   = 1'b0;
                rdoeNext = busWeNext;
                srcNext  = 1'b0;
                weNext   = (sNext == 3'd5 || sNext == 3'd6) ? ~busWeNext : 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            state     <= IDLE;
            S         <= 3'd0;
            phi1Reg   <= 1'b0;
            phi0Seen  <= 1'b0;
            busWeReg  <= 1'b0;
            nRAMCS    <= 1'b1;
            nRAMWE    <= 1'b1;
            RDOE      <= 1'b0;
            RDsrc     <= 1'b0;
            RA        <= '0;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
            bus_inc   <= 1'b0;
        end else begin
            state     <= stateNext;
            S         <= sNext;
            phi1Reg   <= PHI1;
            phi0Seen  <= phi0Seen | ~PHI1;
            busWeReg  <= busWeNext;
            nRAMCS    <= csNext;
            nRAMWE    <= weNext;
            RDOE      <= rdoeNext;
            RDsrc     <= srcNext;
            RA        <= raNext;
            dma_ack   <= ackNext;
            dma_rdata <= rdataNext;
            bus_inc   <= incNext;
        end
    end

endmodule

// File: tb/tb_ram_slot_sequencer.sv
// Bench for ram_slot_sequencer: drives whole bus cycles of chosen length and predicts
// every SRAM strobe from the slot position within the cycle.
module tb_ram_slot_sequencer;

    logic        C7M = 1'b0;
    logic        RES, PHI1, bus_sel, bus_we, dma_req, dma_we;
    logic [19:0] bus_addr, dma_addr;
    logic [7:0]  dma_wdata, RD;
    logic        dma_ack, bus_inc, nRAMCS, nRAMWE, RDOE, RDsrc;
    logic [7:0]  dma_rdata;
    logic [2:0]  S;
    logic [19:0] RA;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: is this the first cycle after (re)sync, was last cycle's DMA aborted,
    // did last cycle carry a completed 6502 access.
    bit firstCycle, abortedPrev, busPrev;

    ram_slot_sequencer #(.ADDR_W(20), .DATA_W(8)) dut (
        .C7M(C7M), .RES(RES), .PHI1(PHI1),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .bus_inc(bus_inc),
        .S(S), .RA(RA), .nRAMCS(nRAMCS), .nRAMWE(nRAMWE),
        .RDOE(RDOE), .RDsrc(RDsrc), .RD(RD)
    );

    always #5 C7M = ~C7M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge C7M);
        #1;
        cyc++;
    endtask

    task automatic checkInactive(input string tag);
        chk({tag, ".S"}, S, 0);
        chk({tag, ".cs"}, nRAMCS, 1);
        chk({tag, ".we"}, nRAMWE, 1);
        chk({tag, ".oe"}, RDOE, 0);
        chk({tag, ".ack"}, dma_ack, 0);
        chk({tag, ".inc"}, bus_inc, 0);
    endtask

    task automatic checkReset();
        checkInactive("rst");
        chk("rst.src", RDsrc, 0);
        chk("rst.ra", RA, 0);
        chk("rst.rdata", dma_rdata, 0);
    endtask

    // Hold PHI1 for n edges without a rising edge; S must stay unsynchronised.
    task automatic holdPhi(input int n, input logic level);
        PHI1 = level;
        for (int k = 0; k < n; k++) begin
            tick();
            checkInactive("presync");
        end
    endtask

    // One bus cycle of L 7M edges. PHI1 rises at slot 0, so after edge i the phase is min(i+1,7).
    task automatic busCycle(input int L, input bit sel, input bit bwe,
                            input logic [19:0] baddr, input logic [7:0] rdv);
        bit go;
        logic expCs, expWe, expOe, expSrc;
        logic [19:0] expRa;
        bit chkRa;
        go = dma_req && !firstCycle && !abortedPrev;
        bus_sel  = sel;
        bus_we   = bwe;
        bus_addr = baddr;
        RD       = rdv;
        for (int i = 0; i < L; i++) begin
            PHI1 = (i == 0) || (i < L / 2);
            tick();
            chk("S", S, (i + 1 > 7) ? 7 : i + 1);
            chk("inc", bus_inc, (i == 0 && busPrev) ? 1 : 0);
            chk("ack", dma_ack, (i == 3 && go) ? 1 : 0);
            if (i == 3 && go) chk("rdata", dma_rdata, rdv);
            expCs = 1'b1; expWe = 1'b1; expOe = 1'b0; expSrc = 1'b0;
            expRa = '0; chkRa = 1'b0;
            if (i < 3 && go) begin
                expCs = 1'b0; expOe = dma_we; expSrc = 1'b1;
                expWe = (i == 1) ? ~dma_we : 1'b1;
                expRa = dma_addr; chkRa = 1'b1;
            end else if (i == 3) begin
                expRa = baddr; chkRa = 1'b1;
            end else if (i >= 4 && sel) begin
                expCs = 1'b0; expOe = bwe;
                expWe = (i <= 5) ? ~bwe : 1'b1;
                expRa = baddr; chkRa = 1'b1;
            end
            chk("cs", nRAMCS, expCs);
            chk("we", nRAMWE, expWe);
            chk("oe", RDOE, expOe);
            if (!expCs) chk("src", RDsrc, expSrc);
            if (chkRa) chk("ra", RA, expRa);
            if (i == 3 && go) dma_req = 1'b0;
        end
        busPrev     = sel && (L >= 5);
        abortedPrev = go && (L < 4);
        firstCycle  = 1'b0;
    endtask

    task automatic setDma(input bit we, input logic [19:0] a, input logic [7:0] d);
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    task automatic resetAndPresync();
        RES = 1'b1; PHI1 = 1'b0;
        tick(); checkReset();
        tick(); checkReset();
        RES = 1'b0;
        holdPhi(3, 1'b1);
        holdPhi(3, 1'b0);
        firstCycle = 1'b1; abortedPrev = 1'b0; busPrev = 1'b0;
    endtask

    initial begin
        int lens[6] = '{2, 3, 7, 7, 7, 8};
        RES = 1'b1; PHI1 = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; RD = '0;

        // DMA write already pending across sync: not granted on the first sync edge.
        setDma(1'b1, 20'h12345, 8'hA5);
        resetAndPresync();
        busCycle(7, 1'b0, 1'b0, 20'h00000, 8'h11);
        busCycle(7, 1'b0, 1'b0, 20'h00000, 8'h22);

        setDma(1'b0, 20'h00010, 8'h00);
        busCycle(7, 1'b0, 1'b0, 20'h00001, 8'h3C);

        setDma(1'b1, 20'hABCDE, 8'h5A);
        busCycle(7, 1'b1, 1'b1, 20'hF00FF, 8'h00);
        busCycle(8, 1'b1, 1'b0, 20'h54321, 8'h77);
        setDma(1'b1, 20'h0BEEF, 8'h99);
        busCycle(7, 1'b0, 1'b0, 20'h00002, 8'h01);

        // PHI1 rises during D_STROBE: aborted, skipped for one cycle, then reissued.
        setDma(1'b1, 20'h33333, 8'hC3);
        busCycle(2, 1'b0, 1'b0, 20'h00003, 8'h02);
        busCycle(7, 1'b0, 1'b0, 20'h00004, 8'h03);
        busCycle(7, 1'b0, 1'b0, 20'h00005, 8'h04);

        // Reset during D_STROBE: strobes drop at that edge, no ack, request survives.
        setDma(1'b0, 20'h44444, 8'h00);
        busCycle(2, 1'b0, 1'b0, 20'h00006, 8'h05);
        RES = 1'b1; PHI1 = 1'b0;
        tick(); checkReset();
        RES = 1'b0;
        holdPhi(2, 1'b0);
        firstCycle = 1'b1; abortedPrev = 1'b0; busPrev = 1'b0;
        busCycle(7, 1'b0, 1'b0, 20'h00007, 8'h06);
        busCycle(7, 1'b1, 1'b1, 20'h00008, 8'h6E);

        for (int n = 0; n < 60; n++) begin
            if (!dma_req && $urandom_range(0, 2) != 0)
                setDma(1'($urandom), 20'($urandom), 8'($urandom));
            busCycle(lens[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
                     20'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
